// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: decode constants,
// status register index, default exception codes and FSM state encoding.
package md_sequencer_pkg;

  localparam logic [4:0] OPC_RTYPE  = 5'b00000;
  localparam logic [4:0] ALU_MUL    = 5'b00110;
  localparam logic [4:0] ALU_DIV    = 5'b00111;
  localparam logic [4:0] STATUS_REG = 5'd30;

  localparam int MUL_EXC_CODE_DEF = 4;
  localparam int DIV_EXC_CODE_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_BUSY   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RETIRE = 3'd4
  } md_state_t;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_op_t;

  // Status word written to the status register when the unit faults.
  function automatic logic [31:0] exc_status(input md_op_t op,
                                             input int     mul_code,
                                             input int     div_code);
    return (op == MD_DIV) ? 32'(div_code) : 32'(mul_code);
  endfunction

endpackage

// File: rtl/md_sequencer_wb_arbiter.sv
// Regfile write-port arbiter for the sequencer. Pipeline writeback owns the
// port whenever wb_we is high; the sequencer only writes in a free WRITE
// cycle. Selects between the destination register and the status register.
module md_sequencer_wb_arbiter
  import md_sequencer_pkg::*;
#(
  parameter int MUL_EXC_CODE = MUL_EXC_CODE_DEF,
  parameter int DIV_EXC_CODE = DIV_EXC_CODE_DEF
) (
  input  logic        in_write,
  input  logic        wb_we,
  input  md_op_t      op,
  input  logic        exc,
  input  logic [4:0]  rd,
  input  logic [31:0] result,
  output logic        write_done,
  output logic        md_we,
  output logic [4:0]  md_writeReg,
  output logic [31:0] md_writeData
);

  // Grant the port when writeback is quiet; rd==0 consumes the slot without writing.
  always_comb begin
    write_done   = in_write & ~wb_we;
    md_we        = 1'b0;
    md_writeReg  = '0;
    md_writeData = '0;
    if (write_done) begin
      if (exc) begin
        md_we        = 1'b1;
        md_writeReg  = STATUS_REG;
        md_writeData = exc_status(op, MUL_EXC_CODE, DIV_EXC_CODE);
      end else if (rd != 5'd0) begin
        md_we        = 1'b1;
        md_writeReg  = rd;
        md_writeData = result;
      end
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer. Detects mul/div in X, pulses the unit start,
// freezes F/D/X until the result is back and written, then retires the
// instruction with its own pipeline write suppressed.
// Optional MD_TIMEOUT_EN: bounds the BUSY wait to TIMEOUT_CYCLES and forces
// an exception when the unit never answers; without it BUSY waits forever.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7,
  parameter int MUL_EXC_CODE   = MUL_EXC_CODE_DEF,
  parameter int DIV_EXC_CODE   = DIV_EXC_CODE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [4:0]  ex_opcode,
  input  logic [4:0]  ex_aluop,
  input  logic [4:0]  ex_rd,
  input  logic        ex_flush,
  input  logic        wb_we,
  input  logic        data_resultRDY,
  input  logic        data_exception,
  input  logic [31:0] data_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        md_we,
  output logic [4:0]  md_writeReg,
  output logic [31:0] md_writeData,
  output logic        x_squash_we
);

  md_state_t   state;
  md_op_t      op_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q;
  logic        exc_q;
  logic        stall_q;
  logic        is_mul;
  logic        is_div;
  logic        is_md;
  logic        write_done;

`ifdef MD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LAST_BUSY = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] busy_cnt;
`endif

  // Decode a live, unsquashed mul/div sitting in X.
  always_comb begin
    is_mul = ex_valid & ~ex_flush & (ex_opcode == OPC_RTYPE) & (ex_aluop == ALU_MUL);
    is_div = ex_valid & ~ex_flush & (ex_opcode == OPC_RTYPE) & (ex_aluop == ALU_DIV);
    is_md  = is_mul | is_div;
  end

  // Stall must rise in the detection cycle itself, before START is registered.
  always_comb begin
    stall = stall_q | ((state == ST_IDLE) & is_md & ~reset);
  end

  md_sequencer_wb_arbiter #(
    .MUL_EXC_CODE (MUL_EXC_CODE),
    .DIV_EXC_CODE (DIV_EXC_CODE)
  ) u_wb_arbiter (
    .in_write     (state == ST_WRITE),
    .wb_we        (wb_we),
    .op           (op_q),
    .exc          (exc_q),
    .rd           (rd_q),
    .result       (result_q),
    .write_done   (write_done),
    .md_we        (md_we),
    .md_writeReg  (md_writeReg),
    .md_writeData (md_writeData)
  );

  // Sequencer FSM with registered start pulses, stall and retire squash.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      op_q        <= MD_MUL;
      rd_q        <= '0;
      result_q    <= '0;
      exc_q       <= 1'b0;
      stall_q     <= 1'b0;
      ctrl_MULT   <= 1'b0;
      ctrl_DIV    <= 1'b0;
      x_squash_we <= 1'b0;
`ifdef MD_TIMEOUT_EN
      busy_cnt    <= '0;
`endif
    end else begin
      ctrl_MULT   <= 1'b0;
      ctrl_DIV    <= 1'b0;
      x_squash_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (is_md) begin
            op_q      <= is_div ? MD_DIV : MD_MUL;
            rd_q      <= ex_rd;
            exc_q     <= 1'b0;
            stall_q   <= 1'b1;
            ctrl_MULT <= is_mul;
            ctrl_DIV  <= is_div;
            state     <= ST_START;
          end
        end
        ST_START: begin
`ifdef MD_TIMEOUT_EN
          busy_cnt <= '0;
`endif
          if (data_resultRDY) begin
            result_q <= data_result;
            exc_q    <= data_exception;
            state    <= ST_WRITE;
          end else begin
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
`ifdef MD_TIMEOUT_EN
          busy_cnt <= busy_cnt + CNT_W'(1);
`endif
          if (data_resultRDY) begin
            result_q <= data_result;
            exc_q    <= data_exception;
            state    <= ST_WRITE;
          end
`ifdef MD_TIMEOUT_EN
          else if (busy_cnt == LAST_BUSY) begin
            exc_q <= 1'b1;
            state <= ST_WRITE;
          end
`endif
        end
        ST_WRITE: begin
          if (write_done) begin
            stall_q     <= 1'b0;
            x_squash_we <= 1'b1;
            state       <= ST_RETIRE;
          end
        end
        ST_RETIRE: begin
          state <= ST_IDLE;
        end
        default: begin
          stall_q <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer. Each operation is described by its
// timeline (RDY delay, writeback conflicts, exception) and the expected
// per-cycle outputs are derived from that timeline.
module tb_md_sequencer;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [4:0]  ex_opcode;
  logic [4:0]  ex_aluop;
  logic [4:0]  ex_rd;
  logic        ex_flush;
  logic        wb_we;
  logic        data_resultRDY;
  logic        data_exception;
  logic [31:0] data_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        md_we;
  logic [4:0]  md_writeReg;
  logic [31:0] md_writeData;
  logic        x_squash_we;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  md_sequencer #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (4),
    .MUL_EXC_CODE   (4),
    .DIV_EXC_CODE   (5)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .ex_aluop       (ex_aluop),
    .ex_rd          (ex_rd),
    .ex_flush       (ex_flush),
    .wb_we          (wb_we),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .data_result    (data_result),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .stall          (stall),
    .md_we          (md_we),
    .md_writeReg    (md_writeReg),
    .md_writeData   (md_writeData),
    .x_squash_we    (x_squash_we)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // Drive an X-stage pattern that must never start the unit.
  task automatic drive_non_md();
    int sel;
    int a;
    sel = $urandom_range(0, 3);
    ex_rd     = 5'($urandom);
    ex_flush  = 1'b0;
    ex_valid  = 1'b1;
    ex_opcode = 5'd0;
    ex_aluop  = $urandom_range(0, 1) ? 5'd6 : 5'd7;
    case (sel)
      0: ex_valid = 1'b0;
      1: ex_flush = 1'b1;
      2: begin
        a = $urandom_range(0, 29);
        if (a >= 6) a = a + 2;
        ex_aluop = 5'(a);
      end
      default: ex_opcode = 5'($urandom_range(1, 31));
    endcase
  endtask

  // Quiet cycles: nothing may issue; RDY pulses are noise.
  task automatic idle_check(input int n, input bit rdy_noise, input string name);
    for (int c = 0; c < n; c++) begin
      drive_non_md();
      wb_we          = 1'($urandom_range(0, 1));
      data_resultRDY = rdy_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      data_exception = 1'($urandom_range(0, 1));
      data_result    = $urandom;
      @(negedge clock);
      checks++;
      if ({stall, ctrl_MULT, ctrl_DIV, md_we, x_squash_we} !== 5'b0) begin
        failures++;
        $display("FAIL %s c=%0d got stall/mult/div/we/sq=%b required 00000",
                 name, c, {stall, ctrl_MULT, ctrl_DIV, md_we, x_squash_we});
      end
      @(posedge clock); #1;
    end
  endtask

  // One complete mul/div, from detection in IDLE through RETIRE.
  // rdy_delay: cycles after START at which RDY arrives (0 = in START).
  // k: WRITE cycles lost to pipeline writeback.
  // no_rdy: the unit never answers (timeout build only).
  task automatic run_op(input bit is_div, input logic [4:0] rd, input int rdy_delay,
                        input bit exc_in, input int k, input bit no_rdy, input string name);
    int t_rdy, t_wr, t_ret;
    logic [31:0] res;
    bit exp_exc, exp_we_any;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic [4:0]  exp_ctl, got_ctl;
    res        = $urandom;
    t_rdy      = no_rdy ? 1 + TO : 1 + rdy_delay;
    t_wr       = t_rdy + 1 + k;
    t_ret      = t_wr + 1;
    exp_exc    = exc_in | no_rdy;
    exp_reg    = exp_exc ? 5'd30 : rd;
    exp_data   = exp_exc ? (is_div ? 32'd5 : 32'd4) : res;
    exp_we_any = exp_exc || (rd != 5'd0);
    for (int t = 0; t <= t_ret; t++) begin
      ex_valid       = 1'b1;
      ex_opcode      = 5'd0;
      ex_aluop       = is_div ? 5'd7 : 5'd6;
      ex_rd          = rd;
      ex_flush       = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      data_resultRDY = 1'b0;
      data_exception = 1'($urandom_range(0, 1));
      data_result    = $urandom;
      if (t == t_rdy && !no_rdy) begin
        data_resultRDY = 1'b1;
        data_exception = exc_in;
        data_result    = res;
      end else if (t > t_rdy && t < t_wr) begin
        data_resultRDY = 1'($urandom_range(0, 1));
      end
      if (t > t_rdy && t < t_wr) wb_we = 1'b1;
      else if (t == t_wr)        wb_we = 1'b0;
      else                       wb_we = 1'($urandom_range(0, 1));
      @(negedge clock);
      exp_ctl = {(t <= t_wr), (t == 1) && !is_div, (t == 1) && is_div,
                 (t == t_wr) && exp_we_any, (t == t_ret)};
      got_ctl = {stall, ctrl_MULT, ctrl_DIV, md_we, x_squash_we};
      checks++;
      if (got_ctl !== exp_ctl) begin
        failures++;
        $display("FAIL %s ctl t=%0d got stall/mult/div/we/sq=%b required %b",
                 name, t, got_ctl, exp_ctl);
      end
      if (exp_ctl[1]) begin
        checks++;
        if ({md_writeReg, md_writeData} !== {exp_reg, exp_data}) begin
          failures++;
          $display("FAIL %s wdata t=%0d got reg=%0d data=%h required reg=%0d data=%h",
                   name, t, md_writeReg, md_writeData, exp_reg, exp_data);
        end
      end
      checks++;
      if (md_we === 1'b1 && wb_we === 1'b1) begin
        failures++;
        $display("FAIL %s port_clash t=%0d got md_we=1 wb_we=1 required not both", name, t);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ex_valid = 1'b0; ex_opcode = '0; ex_aluop = '0; ex_rd = '0; ex_flush = 1'b0;
    wb_we = 1'b0; data_resultRDY = 1'b0; data_exception = 1'b0; data_result = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({stall, ctrl_MULT, ctrl_DIV, md_we, x_squash_we, md_writeReg, md_writeData} !== '0) begin
      failures++;
      $display("FAIL reset_state got stall/mult/div/we/sq=%b reg=%0d data=%h required all 0",
               {stall, ctrl_MULT, ctrl_DIV, md_we, x_squash_we}, md_writeReg, md_writeData);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    idle_check(2, 1'b0, "post_reset_idle");
  endtask

  task automatic test_mul_basic();
    run_op(1'b0, 5'd5, 3, 1'b0, 0, 1'b0, "mul_basic");
    idle_check(2, 1'b0, "mul_basic_after");
  endtask

  task automatic test_div_exception();
    run_op(1'b1, 5'd7, 2, 1'b1, 0, 1'b0, "div_exc");
    run_op(1'b0, 5'd9, 1, 1'b1, 1, 1'b0, "mul_exc");
    idle_check(2, 1'b0, "exc_after");
  endtask

  task automatic test_wb_conflict();
    run_op(1'b0, 5'd12, 0, 1'b0, 2, 1'b0, "wb_conflict");
    run_op(1'b1, 5'd0, 1, 1'b0, 1, 1'b0, "rd0_no_write");
    idle_check(2, 1'b0, "wb_conflict_after");
  endtask

  task automatic test_flush_and_noise();
    for (int c = 0; c < 4; c++) begin
      ex_valid = 1'b1; ex_opcode = 5'd0; ex_aluop = 5'd6; ex_rd = 5'd3; ex_flush = 1'b1;
      wb_we = 1'b0; data_resultRDY = 1'b0;
      @(negedge clock);
      checks++;
      if ({stall, ctrl_MULT, ctrl_DIV} !== 3'b0) begin
        failures++;
        $display("FAIL flush_idle c=%0d got stall/mult/div=%b required 000",
                 c, {stall, ctrl_MULT, ctrl_DIV});
      end
      @(posedge clock); #1;
    end
    idle_check(12, 1'b1, "idle_rdy_noise");
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 5'd4, 1, 1'b0, 0, 1'b0, "b2b_first");
    run_op(1'b1, 5'd6, 0, 1'b0, 0, 1'b0, "b2b_second");
    idle_check(2, 1'b0, "b2b_after");
  endtask

  task automatic test_reset_mid();
    ex_valid = 1'b1; ex_opcode = 5'd0; ex_aluop = 5'd6; ex_rd = 5'd11; ex_flush = 1'b0;
    wb_we = 1'b0; data_resultRDY = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    @(negedge clock); #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_busy got stall=%b required 1", stall);
    end
    reset = 1'b1;
    ex_valid = 1'b0;
    #1;
    checks++;
    if ({stall, ctrl_MULT, ctrl_DIV, md_we, x_squash_we} !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_async got stall/mult/div/we/sq=%b required 00000",
               {stall, ctrl_MULT, ctrl_DIV, md_we, x_squash_we});
    end
    @(posedge clock); #1;
    reset = 1'b0;
    data_resultRDY = 1'b1; data_exception = 1'b0; data_result = 32'hdead_beef;
    @(negedge clock);
    checks++;
    if ({stall, ctrl_MULT, ctrl_DIV, md_we, x_squash_we} !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_late_rdy got stall/mult/div/we/sq=%b required 00000",
               {stall, ctrl_MULT, ctrl_DIV, md_we, x_squash_we});
    end
    @(posedge clock); #1;
    idle_check(3, 1'b1, "reset_mid_idle");
    run_op(1'b0, 5'd11, 2, 1'b0, 0, 1'b0, "reset_mid_reissue");
    idle_check(1, 1'b0, "reset_mid_after");
  endtask

  task automatic test_timeout();
`ifdef MD_TIMEOUT_EN
    run_op(1'b0, 5'd8, 0, 1'b0, 0, 1'b1, "timeout_mul");
    run_op(1'b1, 5'd8, 0, 1'b0, 1, 1'b1, "timeout_div");
`else
    run_op(1'b0, 5'd8, 40, 1'b0, 0, 1'b0, "no_timeout_hold");
`endif
    idle_check(2, 1'b0, "timeout_after");
  endtask

  task automatic test_random();
    int d_max;
    logic [4:0] rd;
`ifdef MD_TIMEOUT_EN
    d_max = TO;
`else
    d_max = 12;
`endif
    for (int n = 0; n < 20; n++) begin
      rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      run_op(1'($urandom_range(0, 1)), rd, $urandom_range(0, d_max),
             1'($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'b0, "random_op");
      if ($urandom_range(0, 1) == 1) idle_check($urandom_range(1, 3), 1'b1, "random_gap");
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_div_exception();
    test_wb_conflict();
    test_flush_and_noise();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
